// File: rtl/cellrv32_cpu_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : cellrv32_cpu_regfile_mp
// Description : Multi-port general-purpose register file for the CELLRV32
//               core. Write-back source mux, optional write-to-read
//               forwarding, out-of-range address detection and a sequential
//               scrub FSM that zeroes every entry after reset or on request,
//               so the storage array itself carries no reset and maps to RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module cellrv32_cpu_regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int FWD_EN   = 1
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     wr_en_i,
  input  logic [4:0]               wr_addr_i,
  input  logic [1:0]               wr_sel_i,
  input  logic [XLEN-1:0]          alu_i,
  input  logic [XLEN-1:0]          mem_i,
  input  logic [XLEN-1:0]          csr_i,
  input  logic [XLEN-1:0]          pc2_i,
  input  logic [NUM_RD-1:0]        rd_en_i,
  input  logic [5*NUM_RD-1:0]      rd_addr_i,
  output logic [XLEN*NUM_RD-1:0]   rd_data_o,
  input  logic                     clr_req_i,
  output logic                     busy_o,
  output logic                     addr_err_o
);

  localparam int              c_AW   = $clog2(NUM_REGS);
  localparam logic [c_AW-1:0] c_LAST = c_AW'(NUM_REGS - 1);

  // Only the RV32I and RV32E register counts are meaningful
  generate
    if (!(NUM_REGS == 16 || NUM_REGS == 32)) begin : g_bad_num_regs
      $error("cellrv32_cpu_regfile_mp: NUM_REGS must be 16 or 32");
    end
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
      $error("cellrv32_cpu_regfile_mp: NUM_RD must be 1..4");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_SCRUB = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [c_AW-1:0]       r_cnt, w_cnt_nxt;
  logic                  w_run;
  logic                  w_wr_oor;
  logic                  w_wr_do;
  logic [XLEN-1:0]       w_wr_data;
  logic [NUM_RD-1:0]     w_rd_oor;
  logic                  r_addr_err;
  logic [XLEN-1:0]       r_regs [NUM_REGS];

  assign w_run  = (r_state == ST_RUN);
  assign busy_o = (r_state == ST_SCRUB);

  // In 16-entry mode the upper half of the 5-bit address space does not exist
  assign w_wr_oor = (NUM_REGS == 16) ? wr_addr_i[4] : 1'b0;

  // A scrub request wins over a coincident write, which is then dropped
  assign w_wr_do = w_run & wr_en_i & (wr_addr_i != 5'd0) & ~w_wr_oor & ~clr_req_i;

  // Next-state logic: scrub walks every entry once, RUN waits for a clear request
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == ST_SCRUB) begin
      if (r_cnt == c_LAST) begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt   = r_cnt + 1'b1;
      end
    end else if (clr_req_i) begin
      w_state_nxt = ST_SCRUB;
      w_cnt_nxt   = '0;
    end
  end

  // State and scrub counter registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_SCRUB;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Write-back source selection
  always_comb begin
    w_wr_data = alu_i;
    case (wr_sel_i)
      2'd0:    w_wr_data = alu_i;
      2'd1:    w_wr_data = mem_i;
      2'd2:    w_wr_data = csr_i;
      default: w_wr_data = pc2_i;
    endcase
  end

  // Single RAM write port shared by the scrubber and normal write-back
  always_ff @(posedge clk_i) begin
    if (!w_run) begin
      r_regs[r_cnt] <= '0;
    end else if (w_wr_do) begin
      r_regs[wr_addr_i[c_AW-1:0]] <= w_wr_data;
    end
  end

  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [4:0]      w_ra;
      logic            w_ra_oor;
      logic            w_fwd;
      logic [XLEN-1:0] w_val;
      logic [XLEN-1:0] r_rd;

      assign w_ra        = rd_addr_i[5*p +: 5];
      assign w_ra_oor    = (NUM_REGS == 16) ? w_ra[4] : 1'b0;
      assign w_rd_oor[p] = rd_en_i[p] & w_ra_oor;
      assign w_fwd       = (FWD_EN != 0) && w_wr_do && (wr_addr_i == w_ra);

      // Read value: x0 and missing entries read 0, optional write-first bypass
      always_comb begin
        w_val = '0;
        if (w_ra == 5'd0 || w_ra_oor) begin
          w_val = '0;
        end else if (w_fwd) begin
          w_val = w_wr_data;
        end else begin
          w_val = r_regs[w_ra[c_AW-1:0]];
        end
      end

      // Registered read data; cleared while scrubbing, held when not enabled
      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          r_rd <= '0;
        end else if (!w_run) begin
          r_rd <= '0;
        end else if (rd_en_i[p]) begin
          r_rd <= w_val;
        end
      end

      assign rd_data_o[p*XLEN +: XLEN] = r_rd;
    end
  endgenerate

  // One error pulse per cycle, however many accesses are out of range
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= w_run & ((wr_en_i & w_wr_oor) | (|w_rd_oor));
    end
  end

  assign addr_err_o = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_cellrv32_cpu_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_cellrv32_cpu_regfile_mp
// Description : Bench for cellrv32_cpu_regfile_mp. Three instances share one
//               stimulus: 32 entries with forwarding, 32 entries without
//               forwarding, 16 entries with forwarding. A behavioural model
//               per instance is compared against every output each cycle,
//               plus literal expectations for the directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cellrv32_cpu_regfile_mp;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [1:0]  wr_sel;
  logic [31:0] alu, mem, csr, pc2;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic        clr_req;

  logic [63:0] rd0, rd1, rd2;
  logic        busy0, busy1, busy2;
  logic        err0, err1, err2;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cellrv32_cpu_regfile_mp #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2), .FWD_EN(1)) u_dut0 (
    .clk_i(clk), .rstn_i(rstn), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_sel_i(wr_sel),
    .alu_i(alu), .mem_i(mem), .csr_i(csr), .pc2_i(pc2), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd0), .clr_req_i(clr_req), .busy_o(busy0), .addr_err_o(err0));

  cellrv32_cpu_regfile_mp #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2), .FWD_EN(0)) u_dut1 (
    .clk_i(clk), .rstn_i(rstn), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_sel_i(wr_sel),
    .alu_i(alu), .mem_i(mem), .csr_i(csr), .pc2_i(pc2), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd1), .clr_req_i(clr_req), .busy_o(busy1), .addr_err_o(err1));

  cellrv32_cpu_regfile_mp #(.XLEN(32), .NUM_REGS(16), .NUM_RD(2), .FWD_EN(1)) u_dut2 (
    .clk_i(clk), .rstn_i(rstn), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_sel_i(wr_sel),
    .alu_i(alu), .mem_i(mem), .csr_i(csr), .pc2_i(pc2), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd2), .clr_req_i(clr_req), .busy_o(busy2), .addr_err_o(err2));

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem  [3][32];
  logic [31:0] m_rd   [3][2];
  logic        m_busy [3];
  logic        m_err  [3];
  int          m_cnt  [3];

  function automatic int nregs(input int i);
    return (i == 2) ? 16 : 32;
  endfunction

  function automatic bit fwd(input int i);
    return (i != 1);
  endfunction

  function automatic bit oor(input int i, input logic [4:0] a);
    return int'(a) >= nregs(i);
  endfunction

  function automatic logic [31:0] wdata();
    case (wr_sel)
      2'd0:    return alu;
      2'd1:    return mem;
      2'd2:    return csr;
      default: return pc2;
    endcase
  endfunction

  function automatic bit wr_ok(input int i);
    return wr_en && (wr_addr != 5'd0) && !oor(i, wr_addr) && !clr_req;
  endfunction

  function automatic logic [31:0] model_read(input int i, input logic [4:0] a);
    if (a == 5'd0 || oor(i, a)) return 32'd0;
    if (fwd(i) && wr_ok(i) && wr_addr == a) return wdata();
    return m_mem[i][a];
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 3; i++) begin
        m_busy[i]  <= 1'b1;
        m_cnt[i]   <= 0;
        m_err[i]   <= 1'b0;
        m_rd[i][0] <= 32'd0;
        m_rd[i][1] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_busy[i]) begin
          m_rd[i][0] <= 32'd0;
          m_rd[i][1] <= 32'd0;
          m_err[i]   <= 1'b0;
          m_cnt[i]   <= m_cnt[i] + 1;
          if (m_cnt[i] == nregs(i) - 1) begin
            m_busy[i] <= 1'b0;
            for (int r = 0; r < 32; r++) m_mem[i][r] <= 32'd0;
          end
        end else begin
          m_err[i] <= (wr_en && oor(i, wr_addr)) ||
                      (rd_en[0] && oor(i, rd_addr[4:0])) ||
                      (rd_en[1] && oor(i, rd_addr[9:5]));
          for (int p = 0; p < 2; p++)
            if (rd_en[p]) m_rd[i][p] <= model_read(i, rd_addr[p*5 +: 5]);
          if (wr_ok(i)) m_mem[i][wr_addr] <= wdata();
          if (clr_req) begin
            m_busy[i] <= 1'b1;
            m_cnt[i]  <= 0;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %h, expected %h (t=%0t)", nm, inst, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [63:0] a_rd;
      logic        a_busy, a_err;
      case (i)
        0:       begin a_rd = rd0; a_busy = busy0; a_err = err0; end
        1:       begin a_rd = rd1; a_busy = busy1; a_err = err1; end
        default: begin a_rd = rd2; a_busy = busy2; a_err = err2; end
      endcase
      chk("busy",     i, {31'd0, a_busy}, {31'd0, m_busy[i]});
      chk("addr_err", i, {31'd0, a_err},  {31'd0, m_err[i]});
      chk("rd_p0",    i, a_rd[31:0],      m_rd[i][0]);
      chk("rd_p1",    i, a_rd[63:32],     m_rd[i][1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    rd_en   = 2'b00;
    clr_req = 1'b0;
  endtask

  task automatic set_wr(input logic [4:0] a, input logic [1:0] sel, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_sel  = sel;
    case (sel)
      2'd0:    alu = d;
      2'd1:    mem = d;
      2'd2:    csr = d;
      default: pc2 = d;
    endcase
  endtask

  task automatic set_rd(input int p, input logic [4:0] a);
    rd_en[p]          = 1'b1;
    rd_addr[p*5 +: 5] = a;
  endtask

  // Counts ticks until busy drops on the 32- and 16-entry instances
  task automatic measure(input int hold_clr, input int exp32, input int exp16);
    int n0;
    int n2;
    n0 = -1;
    n2 = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == hold_clr) clr_req = 1'b0;
      if (!busy0 && n0 < 0) n0 = k;
      if (!busy2 && n2 < 0) n2 = k;
    end
    chk("busy_len32", 0, n0, exp32);
    chk("busy_len16", 2, n2, exp16);
  endtask

  initial begin
    rstn    = 1'b0;
    idle();
    wr_addr = 5'd0;
    wr_sel  = 2'd0;
    rd_addr = 10'd0;
    alu     = 32'h0A1A_0A1A;
    mem     = 32'h0B2B_0B2B;
    csr     = 32'h0C3C_0C3C;
    pc2     = 32'h0D4D_0D4D;
    repeat (3) tick();
    chk("rst_busy", 0, {31'd0, busy0}, 32'd1);
    chk("rst_rd",   0, rd0[31:0], 32'd0);
    chk("rst_err",  2, {31'd0, err2}, 32'd0);

    // Reset release: scrub length equals the entry count
    rstn = 1'b1;
    measure(0, 32, 16);

    // All entries read zero after the scrub
    for (int r = 1; r < 32; r++) begin
      idle();
      set_rd(0, 5'(r));
      set_rd(1, 5'(32 - r));
      tick();
      chk("post_scrub_rd", 0, rd0[31:0], 32'd0);
    end
    idle();

    // Memory-sourced write then read back
    set_wr(5'd5, 2'd1, 32'hDEAD_BEEF);
    tick(); idle();
    set_rd(0, 5'd5);
    tick(); idle();
    chk("x5_rd",    0, rd0[31:0], 32'hDEAD_BEEF);
    chk("x5_rd_16", 2, rd2[31:0], 32'hDEAD_BEEF);

    // x0 is hard-wired to zero
    set_wr(5'd0, 2'd0, 32'h0000_1234);
    tick(); idle();
    set_rd(0, 5'd0);
    tick(); idle();
    chk("x0_rd", 0, rd0[31:0], 32'd0);

    // Same-cycle write/read of x7: forwarding vs read-first
    set_wr(5'd7, 2'd2, 32'h0000_0001);
    tick(); idle();
    set_wr(5'd7, 2'd3, 32'hA5A5_A5A5);
    set_rd(1, 5'd7);
    tick(); idle();
    chk("fwd_x7",   0, rd0[63:32], 32'hA5A5_A5A5);
    chk("nofwd_x7", 1, rd1[63:32], 32'h0000_0001);
    set_rd(1, 5'd7);
    tick(); idle();
    chk("reread_x7", 1, rd1[63:32], 32'hA5A5_A5A5);

    // Out-of-range write in 16-entry mode
    set_wr(5'd20, 2'd0, 32'h0000_0055);
    tick(); idle();
    chk("err_wr20",   2, {31'd0, err2}, 32'd1);
    chk("noerr_wr20", 0, {31'd0, err0}, 32'd0);
    set_rd(0, 5'd4);
    tick(); idle();
    chk("err_pulse_end", 2, {31'd0, err2}, 32'd0);
    chk("x4_unaliased",  2, rd2[31:0], 32'd0);

    // Out-of-range read on both ports: single pulse, data 0
    set_rd(0, 5'd17);
    set_rd(1, 5'd30);
    tick(); idle();
    chk("err_rd17", 2, {31'd0, err2}, 32'd1);
    chk("rd17_16",  2, rd2[31:0], 32'd0);

    // Fill x1..x31 with their index
    for (int r = 1; r < 32; r++) begin
      idle();
      set_wr(5'(r), 2'd0, 32'(r));
      tick();
    end
    idle();
    set_rd(0, 5'd9);
    set_rd(1, 5'd9);
    tick(); idle();
    chk("same_addr_p0", 0, rd0[31:0],  32'd9);
    chk("same_addr_p1", 0, rd0[63:32], 32'd9);

    // Clear request with a coincident write: write dropped, reads complete
    clr_req = 1'b1;
    set_wr(5'd3, 2'd1, 32'h0000_0099);
    set_rd(0, 5'd5);
    set_rd(1, 5'd3);
    tick();
    wr_en = 1'b0;
    rd_en = 2'b00;
    chk("clr_rd5", 0, rd0[31:0],  32'd5);
    chk("clr_rd3", 0, rd0[63:32], 32'd3);
    chk("clr_busy", 0, {31'd0, busy0}, 32'd1);
    measure(3, 32, 16);
    for (int r = 1; r < 32; r++) begin
      idle();
      set_rd(0, 5'(r));
      tick();
    end
    idle();
    set_rd(1, 5'd3);
    tick(); idle();
    chk("x3_after_clr", 0, rd0[63:32], 32'd0);

    // Reset in the middle of a scrub restarts it from the beginning
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (9) tick();
    rstn = 1'b0;
    tick();
    chk("midrst_busy", 0, {31'd0, busy0}, 32'd1);
    chk("midrst_rd",   0, rd0[31:0], 32'd0);
    tick();
    rstn = 1'b1;
    measure(0, 32, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
